// File: rtl/interp_upsampler_pkg.sv
// rtl/interp_upsampler_pkg.sv - shared FSM state type and parameter range limits for interp_upsampler
package interp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int DATA_W_MIN = 2;
    localparam int DATA_W_MAX = 32;
    localparam int FACTOR_MIN = 2;
    localparam int FACTOR_MAX = 16;

endpackage

// File: rtl/interp_upsampler_if.sv
// rtl/interp_upsampler_if.sv - sample-in / sample-out handshake bundle for interp_upsampler
interface interp_upsampler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_first
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_first
    );
endinterface

// File: rtl/interp_upsampler_phase_cnt.sv
// rtl/interp_upsampler_phase_cnt.sv - modulo-FACTOR phase counter with last-phase flag
module interp_phase_cnt #(
    parameter int FACTOR = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      adv,
    output logic [$clog2(FACTOR)-1:0] phase,
    output logic                      last
);
    localparam int PW = $clog2(FACTOR);
    localparam logic [PW-1:0] LAST_PHASE = PW'(FACTOR - 1);

    assign last = (phase == LAST_PHASE);

    // clr wins over adv so a new sample always restarts at phase 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (adv) begin
            phase <= last ? '0 : phase + 1'b1;
        end
    end
endmodule

// File: rtl/interp_upsampler.sv
// rtl/interp_upsampler.sv - 1:FACTOR zero-insert upsampler; INTERP_HOLD_EN adds zero-order-hold mode
module interp_upsampler
    import interp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FACTOR = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef INTERP_HOLD_EN
    input  logic hold_mode,
`endif
    interp_upsampler_if.slave bus
);
    localparam int PW = $clog2(FACTOR);
    localparam logic [PW-1:0] LAST_PHASE = PW'(FACTOR - 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        FACTOR < FACTOR_MIN || FACTOR > FACTOR_MAX) begin : g_param_check
        $error("interp_upsampler: DATA_W or FACTOR out of range");
    end

    state_t            state;
    logic [DATA_W-1:0] sample;
    logic [PW-1:0]     phase;
    logic              last;
    logic              in_xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] fill;

`ifdef INTERP_HOLD_EN
    logic hold_q;
`else
    localparam logic hold_q = 1'b0;
`endif

    assign bus.in_ready = reset && ((state == IDLE) ||
                                    (phase == LAST_PHASE && bus.out_ready));
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;
    assign fill     = hold_q ? sample : '0;

    interp_phase_cnt #(.FACTOR(FACTOR)) u_phase (
        .clk   (clk),
        .reset (reset),
        .clr   (in_xfer),
        .adv   (out_xfer),
        .phase (phase),
        .last  (last)
    );

    // A capture on the last-phase transfer takes priority, giving back-to-back samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            sample        <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
`ifdef INTERP_HOLD_EN
            hold_q        <= 1'b0;
`endif
        end else if (in_xfer) begin
            state         <= EMIT;
            sample        <= bus.in_data;
            bus.out_data  <= bus.in_data;
            bus.out_valid <= 1'b1;
            bus.out_first <= 1'b1;
`ifdef INTERP_HOLD_EN
            hold_q        <= hold_mode;
`endif
        end else if (out_xfer) begin
            bus.out_first <= 1'b0;
            if (last) begin
                state         <= IDLE;
                bus.out_valid <= 1'b0;
                bus.out_data  <= '0;
            end else begin
                bus.out_data  <= fill;
            end
        end
    end
endmodule
